spi_controller: RTL and testbench
=================================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter HALF_PERIOD, default 4: clk cycles per SCLK half-period; legal range 2..255.
REQ-002 Parameter CS_GAP, default 4: clk cycles NCS is held high after a frame before the next request is accepted; legal range 1..255.
REQ-003 Port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  1  write request present.
REQ-006 Port req_ready  output  1  controller can accept a request this cycle.
REQ-007 Port req_addr  input  7  target register address.
REQ-008 Port req_data  input  8  register write data.
REQ-009 Port sclk  output  1  SPI serial clock, mode 0 (idle low).
REQ-010 Port copi  output  1  SPI controller-out data, MSB first.
REQ-011 Port ncs  output  1  SPI chip select, active low.
REQ-012 Port busy  output  1  high whenever the state is not IDLE.
REQ-013 Port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-014 The block SHALL implement states IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD and GAP.
REQ-015 The block SHALL capture a request in the cycle where req_valid and req_ready are both high, latching the 16-bit frame {1'b1, req_addr, req_data}, whose MSB is the write flag.
REQ-016 The block SHALL drive req_ready high only in IDLE and not in reset.
REQ-017 The block SHALL ignore changes on req_addr and req_data after capture.
REQ-018 The block SHALL ignore req_valid in every state other than IDLE.
REQ-019 In the cycle after capture, the block SHALL drive ncs=0, sclk=0 and copi=frame[15], and enter SETUP.
REQ-020 SETUP SHALL last HALF_PERIOD cycles and then enter SHIFT_HI.
REQ-021 In SHIFT_HI, the block SHALL hold sclk=1 for HALF_PERIOD cycles with copi unchanged, giving the peripheral a rising-edge sample point.
REQ-022 After SHIFT_HI with bits remaining, the block SHALL drive sclk=0 and copi to the next lower bit in the same cycle, then hold SHIFT_LO for HALF_PERIOD cycles before returning to SHIFT_HI.
REQ-023 The block SHALL produce exactly 16 sclk rising edges per frame.
REQ-024 After the 16th SHIFT_HI, the block SHALL drive sclk=0 and enter HOLD for HALF_PERIOD cycles with ncs still 0.
REQ-025 On leaving HOLD, the block SHALL drive ncs=1 and copi=0, pulse done for exactly that cycle, and enter GAP.
REQ-026 GAP SHALL last CS_GAP cycles and then enter IDLE.
REQ-027 Total ncs-low time SHALL be 33*HALF_PERIOD cycles; capture to the next req_ready SHALL take 33*HALF_PERIOD+CS_GAP+1 cycles.
REQ-028 In IDLE and GAP, the block SHALL hold ncs=1, sclk=0 and copi=0.
REQ-029 sclk, copi and ncs SHALL be driven directly from flops, with no combinational paths from inputs.
REQ-030 The half-period counter SHALL be wide enough for 255 and SHALL reload on every phase change.
REQ-031 The bit counter SHALL count 15 down to 0 with no wrap-around.
REQ-032 A request presented in the same cycle the block returns to IDLE SHALL be accepted, since req_ready is already high in that cycle.

Reset
REQ-033 While rst=1, the block SHALL drive ncs=1, sclk=0, copi=0, busy=0, done=0 and req_ready=0, and the state SHALL be IDLE.
REQ-034 req_ready SHALL go high in the first cycle after rst deasserts.
REQ-035 Reset asserted mid-frame SHALL abort the frame: the next cycle shows ncs=1 and sclk=0, no done pulse is produced, and the latched frame is discarded.
REQ-036 A req_valid present while rst=1 SHALL NOT be captured.

Verification
REQ-037 Single write: HALF_PERIOD=4, req_addr=0x00, req_data=0xF0 -> the bits sampled on the 16 sclk rising edges equal 0x80F0, ncs is low for 132 cycles, and done pulses once.
REQ-038 End to end: frames addr 0x04 data 0x01 and addr 0x02 data 0x01 driven into the existing spi_peripheral/pwm_peripheral pair -> en_reg_pwm_7_0=0x01 and en_reg_out_7_0=0x01.
REQ-039 Back-to-back: req_valid held high for two requests -> second ncs falling edge occurs CS_GAP+1 cycles after the first ncs rising edge, and both frames are intact.
REQ-040 Busy ignore: req_valid toggled with new addr/data during SHIFT states -> the frame in flight is unchanged and no extra frame is sent.
REQ-041 Reset mid-frame: rst asserted after the 7th rising edge -> next cycle ncs=1, sclk=0, no done pulse; a following request sends a full clean 16-bit frame.
REQ-042 Minimum divider: HALF_PERIOD=2, CS_GAP=1 -> each sclk phase lasts 2 cycles, the frame is 66 cycles, and the peripheral decodes it correctly.

Source files
------------

// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller.
// Sends one 16-bit frame {write flag, 7-bit address, 8-bit data}, MSB first,
// then holds chip select high for a minimum gap before accepting the next request.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a request; ncs high, req_ready high
// SETUP    | ncs low, first bit on copi, sclk low for one half-period
// SHIFT_HI | sclk high; the peripheral samples copi on the rising edge
// SHIFT_LO | sclk low; copi moved to the next lower bit
// HOLD     | sclk low after the last bit; ncs still low
// GAP      | ncs high for CS_GAP cycles before returning to IDLE
module spi_controller #(
   parameter int HALF_PERIOD = 4,
   parameter int CS_GAP      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_data,
   output logic       sclk,
   output logic       copi,
   output logic       ncs,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_LO,
      SHIFT_HI,
      HOLD,
      GAP
   } state_t;

   localparam logic [7:0] HP_LOAD  = 8'(HALF_PERIOD - 1);
   localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  cnt;
   logic [3:0]  bit_cnt;
   // Bits below the write flag; the flag itself is always 1 and goes straight to copi.
   logic [14:0] frame_sr;
   logic        tc;
   logic        phase_chg;

   assign tc        = (cnt == 8'd0);
   assign phase_chg = (state_nxt != state);
   assign busy      = (state != IDLE);
   assign req_ready = (state == IDLE) && !rst;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection; every phase ends when the down-counter reaches zero.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (req_valid) state_nxt = SETUP;
         SETUP:    if (tc) state_nxt = SHIFT_HI;
         SHIFT_HI: if (tc) state_nxt = (bit_cnt == 4'd0) ? HOLD : SHIFT_LO;
         SHIFT_LO: if (tc) state_nxt = SHIFT_HI;
         HOLD:     if (tc) state_nxt = GAP;
         GAP:      if (tc) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Phase timer: reloads on every state change, otherwise counts down to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 8'd0;
      end else if (phase_chg) begin
         cnt <= (state_nxt == GAP) ? GAP_LOAD : HP_LOAD;
      end else if (!tc) begin
         cnt <= cnt - 8'd1;
      end
   end

   // Frame shift register, bit counter and registered SPI pins.
   // Pins are computed from the next state so they change on the same edge as the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_sr <= 15'd0;
         bit_cnt  <= 4'd0;
         copi     <= 1'b0;
         sclk     <= 1'b0;
         ncs      <= 1'b1;
         done     <= 1'b0;
      end else begin
         sclk <= (state_nxt == SHIFT_HI);
         ncs  <= (state_nxt == IDLE) || (state_nxt == GAP);
         done <= (state == HOLD) && (state_nxt == GAP);
         if (state == IDLE && req_valid) begin
            frame_sr <= {req_addr, req_data};
            bit_cnt  <= 4'd15;
            copi     <= 1'b1;
         end else if (state == SHIFT_HI && state_nxt == SHIFT_LO) begin
            frame_sr <= {frame_sr[13:0], 1'b0};
            bit_cnt  <= bit_cnt - 4'd1;
            copi     <= frame_sr[14];
         end else if (state_nxt == GAP) begin
            copi <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: instance 0 uses the default timing,
// instance 1 the minimum divider and gap.
module tb_spi_controller;

   localparam int HP0  = 4;
   localparam int GAP0 = 4;
   localparam int HP1  = 2;
   localparam int GAP1 = 1;

   logic       clk = 1'b0;
   logic       rst_s    [2];
   logic       valid_s  [2];
   logic [6:0] addr_s   [2];
   logic [7:0] data_s   [2];
   logic       ready_s  [2];
   logic       sclk_s   [2];
   logic       copi_s   [2];
   logic       ncs_s    [2];
   logic       busy_s   [2];
   logic       done_s   [2];

   int tests_run = 0;
   int tests_failed = 0;

   // hand-computed: ncs-low length and capture-to-ready latency per instance
   int low_len [2] = '{132, 66};
   int lat_len [2] = '{137, 68};

   logic [15:0] q0[$];
   logic [15:0] q1[$];

   int          cyc       [2] = '{0, 0};
   int          rise_cyc  [2] = '{0, 0};
   int          gap_cyc   [2] = '{0, 0};
   int          nbits     [2] = '{0, 0};
   int          low_cnt   [2] = '{0, 0};
   int          frames    [2] = '{0, 0};
   logic [15:0] shreg     [2];
   logic        prev_sclk [2] = '{1'b0, 1'b0};
   logic        prev_ncs  [2] = '{1'b1, 1'b1};

   always #5 clk = ~clk;

   spi_controller #(.HALF_PERIOD(HP0), .CS_GAP(GAP0)) dut0 (
      .clk(clk), .rst(rst_s[0]), .req_valid(valid_s[0]), .req_ready(ready_s[0]),
      .req_addr(addr_s[0]), .req_data(data_s[0]), .sclk(sclk_s[0]), .copi(copi_s[0]),
      .ncs(ncs_s[0]), .busy(busy_s[0]), .done(done_s[0])
   );

   spi_controller #(.HALF_PERIOD(HP1), .CS_GAP(GAP1)) dut1 (
      .clk(clk), .rst(rst_s[1]), .req_valid(valid_s[1]), .req_ready(ready_s[1]),
      .req_addr(addr_s[1]), .req_data(data_s[1]), .sclk(sclk_s[1]), .copi(copi_s[1]),
      .ncs(ncs_s[1]), .busy(busy_s[1]), .done(done_s[1])
   );

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, idx, act, exp, $time);
      end
   endtask

   // Monitor: reconstruct each frame from copi at sclk rising edges and pop the scoreboard at ncs rise.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         cyc[i]++;
         if (rst_s[i]) begin
            if (done_s[i]) chk("done_in_reset", i, 32'(done_s[i]), 0);
            nbits[i]     = 0;
            low_cnt[i]   = 0;
            prev_sclk[i] = sclk_s[i];
            prev_ncs[i]  = ncs_s[i];
         end else begin
            if (!ncs_s[i] && prev_ncs[i]) begin
               gap_cyc[i] = cyc[i] - rise_cyc[i];
               nbits[i]   = 0;
               low_cnt[i] = 0;
            end
            if (!ncs_s[i]) low_cnt[i]++;
            if (ncs_s[i] && (sclk_s[i] || copi_s[i]))
               chk("idle_pins", i, {30'd0, sclk_s[i], copi_s[i]}, 0);
            if (sclk_s[i] && !prev_sclk[i]) begin
               if (ncs_s[i]) chk("sclk_with_ncs_high", i, 32'(ncs_s[i]), 0);
               shreg[i] = {shreg[i][14:0], copi_s[i]};
               nbits[i]++;
            end
            if (ncs_s[i] && !prev_ncs[i]) begin
               rise_cyc[i] = cyc[i];
               frames[i]++;
               if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                  chk("extra_frame", i, 32'(shreg[i]), 32'hFFFF_FFFF);
               end else begin
                  chk("frame", i, 32'(shreg[i]), 32'((i == 0) ? q0.pop_front() : q1.pop_front()));
               end
               chk("rising_edges", i, nbits[i], 16);
               chk("ncs_low_cycles", i, low_cnt[i], low_len[i]);
               chk("done_at_end", i, 32'(done_s[i]), 1);
            end else if (done_s[i]) begin
               chk("stray_done", i, 32'(done_s[i]), 0);
            end
            prev_sclk[i] = sclk_s[i];
            prev_ncs[i]  = ncs_s[i];
         end
      end
   end

   task automatic wait_ready(input int idx);
      int n = 0;
      while (!ready_s[idx] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("ready_timeout", idx, 0, 1);
   endtask

   task automatic send(input int idx, input logic [6:0] a, input logic [7:0] d,
                       input logic [15:0] exp, input bit lat);
      int n;
      wait_ready(idx);
      valid_s[idx] = 1'b1;
      addr_s[idx]  = a;
      data_s[idx]  = d;
      if (idx == 0) q0.push_back(exp); else q1.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      valid_s[idx] = 1'b0;
      addr_s[idx]  = ~a;
      data_s[idx]  = ~d;
      if (lat) begin
         n = 1;
         while (!ready_s[idx] && n < 2000) begin
            @(negedge clk);
            n++;
         end
         chk("capture_to_ready", idx, n, lat_len[idx]);
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_s[i] = 1'b1;
         valid_s[i] = 1'b1;
         addr_s[i] = 7'h15;
         data_s[i] = 8'h5A;
      end
      repeat (3) @(negedge clk);
      // reset state with req_valid asserted
      chk("rst_ncs", 0, 32'(ncs_s[0]), 1);
      chk("rst_sclk", 0, 32'(sclk_s[0]), 0);
      chk("rst_copi", 0, 32'(copi_s[0]), 0);
      chk("rst_busy", 0, 32'(busy_s[0]), 0);
      chk("rst_done", 0, 32'(done_s[0]), 0);
      chk("rst_ready", 0, 32'(ready_s[0]), 0);
      valid_s[0] = 1'b0;
      valid_s[1] = 1'b0;
      rst_s[0] = 1'b0;
      rst_s[1] = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 0, 32'(ready_s[0]), 1);
      chk("ready_after_rst", 1, 32'(ready_s[1]), 1);

      // single writes
      send(0, 7'h00, 8'hF0, 16'h80F0, 1);
      send(0, 7'h04, 8'h01, 16'h8401, 1);
      send(0, 7'h02, 8'h01, 16'h8201, 1);

      // back-to-back with req_valid held high
      wait_ready(0);
      valid_s[0] = 1'b1;
      addr_s[0] = 7'h11;
      data_s[0] = 8'hA5;
      q0.push_back(16'h91A5);
      @(posedge clk);
      @(negedge clk);
      addr_s[0] = 7'h7F;
      data_s[0] = 8'h3C;
      q0.push_back(16'hFF3C);
      @(negedge clk);
      wait_ready(0);
      @(posedge clk);
      @(negedge clk);
      valid_s[0] = 1'b0;
      wait_ready(0);
      chk("b2b_gap", 0, gap_cyc[0], GAP0 + 1);

      // requests toggled while busy must be ignored
      send(0, 7'h55, 8'hAA, 16'hD5AA, 0);
      for (int k = 0; k < 40; k++) begin
         valid_s[0] = k[0];
         addr_s[0] = 7'(k);
         data_s[0] = 8'(k * 3);
         @(negedge clk);
      end
      valid_s[0] = 1'b0;
      wait_ready(0);

      // reset after the 7th rising edge aborts the frame
      wait_ready(0);
      valid_s[0] = 1'b1;
      addr_s[0] = 7'h33;
      data_s[0] = 8'h0F;
      @(posedge clk);
      @(negedge clk);
      valid_s[0] = 1'b0;
      begin
         int n = 0;
         while (nbits[0] != 7 && n < 2000) begin
            @(posedge clk);
            n++;
         end
         if (n >= 2000) chk("wait_7th_edge", 0, 0, 1);
      end
      @(negedge clk);
      rst_s[0] = 1'b1;
      valid_s[0] = 1'b1;
      @(negedge clk);
      chk("abort_ncs", 0, 32'(ncs_s[0]), 1);
      chk("abort_sclk", 0, 32'(sclk_s[0]), 0);
      chk("abort_busy", 0, 32'(busy_s[0]), 0);
      @(negedge clk);
      valid_s[0] = 1'b0;
      rst_s[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("no_capture_in_rst", 0, 32'(busy_s[0]), 0);
      send(0, 7'h2A, 8'h81, 16'hAA81, 1);

      // minimum divider instance
      send(1, 7'h7F, 8'hFF, 16'hFFFF, 1);
      send(1, 7'h01, 8'h00, 16'h8100, 1);

      repeat (10) @(negedge clk);
      chk("frames_sent", 0, frames[0], 7);
      chk("frames_sent", 1, frames[1], 2);
      chk("scoreboard_empty", 0, q0.size(), 0);
      chk("scoreboard_empty", 1, q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
